// File: rtl/stopwatch_core_pkg.sv
// Shared types and constants for the stopwatch counter/display stage.
package stopwatch_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned NUM_DIGITS      = 6;
  localparam int unsigned MAX_DEC         = 9;
  localparam int unsigned MAX_SEX         = 5;
  localparam int unsigned CLK_DIV_DEFAULT = 500000;

  // Display word, most significant digit first.
  typedef struct packed {
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_o;
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_o;
    logic [DIGIT_W-1:0] cs_t;
    logic [DIGIT_W-1:0] cs_o;
  } count_t;

  // Prescaler width; a divide-by-1 still needs one bit to hold the constant 0.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch carry chain; rolls MAX -> 0 and raises carry.
module bcd_digit_cnt
  import stopwatch_core_pkg::*;
#(
  parameter int unsigned MAX = MAX_DEC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic at_max;

  assign at_max = (q == DIGIT_W'(MAX));
  assign carry  = inc && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch MM:SS.cc BCD counter with start/stop, clear and lap freeze.
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_stopwatch,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam int unsigned   PW         = presc_width(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  state_t                                 state;
  logic   [PW-1:0]                        presc;
  count_t                                 live;
  count_t                                 snap;
  count_t                                 shown;
  logic   [NUM_DIGITS-1:0][DIGIT_W-1:0]   dig;
  logic   [NUM_DIGITS:0]                  chain;
  logic                                   start;
  logic                                   clr;
  logic                                   lap;
  logic                                   counting;
  logic                                   tick;
  logic                                   clr_cnt;

  // Buttons only act while this block owns the front panel.
  assign start = mode_stopwatch && btn_start;
  assign clr   = mode_stopwatch && btn_clr;
  assign lap   = mode_stopwatch && btn_lap;

  assign counting = (state == ST_RUN) || (state == ST_LAP);
  assign tick     = counting && (presc == PRESC_LAST);
  assign clr_cnt  = (state == ST_PAUSE) && clr && !start;

  // Carry chain: digit 0 is cs_o, digit 5 is min_t; chain[6] is the full roll-over.
  assign chain[0] = tick;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cnt #(
      .MAX((i == 3 || i == 5) ? MAX_SEX : MAX_DEC)
    ) u_digit (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_cnt),
      .inc  (chain[i]),
      .q    (dig[i]),
      .carry(chain[i+1])
    );
  end

  assign live  = count_t'(dig);
  assign shown = (state == ST_LAP) ? snap : live;
  assign {min_t, min_o, sec_t, sec_o, cs_t, cs_o} = shown;

  // Control FSM, prescaler, lap snapshot and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      presc      <= '0;
      snap       <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      wrap <= chain[NUM_DIGITS];

      if (clr_cnt || tick) begin
        presc <= '0;
      end else if (counting) begin
        presc <= presc + PW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (start) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (lap) begin
            state      <= ST_LAP;
            lap_active <= 1'b1;
            snap       <= live;
          end
        end
        ST_LAP: begin
          if (start) begin
            state      <= ST_PAUSE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap) begin
            state      <= ST_RUN;
            lap_active <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (clr) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          running    <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core against a centisecond-count reference model.
module tb_stopwatch_core;

  localparam int unsigned DIV  = 4;
  localparam int          FULL = 360000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mode, bs, bc, bl;
  logic [3:0] min_t, min_o, sec_t, sec_o, cs_t, cs_o;
  logic       running, lap_active, wrap;
  logic [23:0] disp;

  logic       rst1, bs1;
  logic [3:0] x_min_t, x_min_o, x_sec_t, x_sec_o, x_cs_t, x_cs_o;
  logic       run1, lap1, w1;
  logic [23:0] disp1;

  assign disp  = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
  assign disp1 = {x_min_t, x_min_o, x_sec_t, x_sec_o, x_cs_t, x_cs_o};

  stopwatch_core #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .mode_stopwatch(mode),
    .btn_start(bs), .btn_clr(bc), .btn_lap(bl),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .cs_t(cs_t), .cs_o(cs_o),
    .running(running), .lap_active(lap_active), .wrap(wrap)
  );

  stopwatch_core #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .mode_stopwatch(1'b1),
    .btn_start(bs1), .btn_clr(1'b0), .btn_lap(1'b0),
    .min_t(x_min_t), .min_o(x_min_o), .sec_t(x_sec_t), .sec_o(x_sec_o),
    .cs_t(x_cs_t), .cs_o(x_cs_o),
    .running(run1), .lap_active(lap1), .wrap(w1)
  );

  // Reference model: whole count kept as elapsed centiseconds.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_t;
  mstate_t m_state;
  int      m_cnt, m_snap, m_presc;
  bit      m_wrap;
  int      n_checks = 0;
  int      n_fail   = 0;

  function automatic logic [23:0] to_bcd(input int c);
    int mm, ss, cc;
    mm = c / 6000;
    ss = (c / 100) % 60;
    cc = c % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [23:0] exp_disp();
    return to_bcd(m_state == M_LAP ? m_snap : m_cnt);
  endfunction

  function automatic bit exp_running();
    return (m_state == M_RUN) || (m_state == M_LAP);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_snap = 0; m_presc = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit s, input bit c, input bit l, input bit m);
    bit counting;
    int n_cnt, n_presc;
    counting = exp_running();
    n_cnt = m_cnt; n_presc = m_presc; m_wrap = 0;
    if (counting) begin
      if (m_presc == int'(DIV) - 1) begin
        n_presc = 0;
        n_cnt = (m_cnt + 1) % FULL;
        m_wrap = (m_cnt == FULL - 1);
      end else begin
        n_presc = m_presc + 1;
      end
    end
    if (m) begin
      case (m_state)
        M_IDLE:  if (s) m_state = M_RUN;
        M_RUN:   if (s) m_state = M_PAUSE;
                 else if (l) begin m_snap = m_cnt; m_state = M_LAP; end
        M_LAP:   if (s) m_state = M_PAUSE;
                 else if (l) m_state = M_RUN;
        M_PAUSE: if (s) m_state = M_RUN;
                 else if (c) begin m_state = M_IDLE; n_cnt = 0; n_presc = 0; end
      endcase
    end
    m_cnt = n_cnt; m_presc = n_presc;
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic cycle(input bit s, input bit c, input bit l);
    bs = s; bc = c; bl = l;
    @(posedge clk);
    model_edge(s, c, l, mode);
    @(negedge clk);
    bs = 0; bc = 0; bl = 0;
  endtask

  task automatic test_reset();
    rst = 1; rst1 = 1; mode = 1; bs = 0; bc = 0; bl = 0; bs1 = 0;
    model_reset();
    @(negedge clk);
    n_checks++; if (disp !== 24'h0) begin n_fail++; $display("FAIL reset_disp: got %h want %h", disp, 24'h0); end
    n_checks++; if (running !== 1'b0 || lap_active !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got run=%b lap=%b wrap=%b want 000", running, lap_active, wrap); end
    rst = 0;
    cycle(0, 1, 1);
    n_checks++; if (running !== 1'b0 || disp !== 24'h0) begin
      n_fail++; $display("FAIL idle_ignore: got run=%b disp=%h want 0/000000", running, disp); end
  endtask

  task automatic test_start_run();
    cycle(1, 0, 0);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b want 1", running); end
    for (int k = 1; k < int'(DIV); k++) begin
      cycle(0, 0, 0);
      n_checks++; if (disp !== 24'h0) begin n_fail++; $display("FAIL prescale_hold k=%0d: got %h want 000000", k, disp); end
    end
    repeat (400 - (DIV - 1)) cycle(0, 0, 0);
    n_checks++; if (disp !== 24'h000100 || disp !== exp_disp()) begin
      n_fail++; $display("FAIL run_1s: got %h want 000100 (model %h)", disp, exp_disp()); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_flag: got %b want 1", running); end
  endtask

  task automatic test_pause_clear();
    cycle(1, 0, 0);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_flag: got %b want 0", running); end
    repeat (1000) cycle(0, 0, 0);
    n_checks++; if (disp !== 24'h000100 || disp !== exp_disp()) begin
      n_fail++; $display("FAIL pause_hold: got %h want 000100", disp); end
    cycle(0, 1, 0);
    n_checks++; if (disp !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0) begin
      n_fail++; $display("FAIL clear: got disp=%h run=%b lap=%b want 000000/0/0", disp, running, lap_active); end
    repeat (10) cycle(0, 0, 0);
    n_checks++; if (disp !== 24'h0) begin n_fail++; $display("FAIL idle_hold: got %h want 000000", disp); end
  endtask

  task automatic test_lap();
    cycle(1, 0, 0);
    repeat (200) cycle(0, 0, 0);
    n_checks++; if (disp !== 24'h000050) begin n_fail++; $display("FAIL lap_pre: got %h want 000050", disp); end
    cycle(0, 0, 1);
    n_checks++; if (lap_active !== 1'b1 || running !== 1'b1) begin
      n_fail++; $display("FAIL lap_flags: got lap=%b run=%b want 1/1", lap_active, running); end
    for (int k = 0; k < 199; k++) begin
      cycle(0, 0, 0);
      if (k % 50 == 49) begin
        n_checks++; if (disp !== 24'h000050) begin n_fail++; $display("FAIL lap_frozen k=%0d: got %h want 000050", k, disp); end
      end
    end
    cycle(0, 0, 1);
    n_checks++; if (disp !== 24'h000100 || lap_active !== 1'b0) begin
      n_fail++; $display("FAIL lap_release: got %h lap=%b want 000100/0", disp, lap_active); end
    repeat (37) cycle(0, 0, 0);
    cycle(0, 0, 1);
    repeat (41) cycle(0, 0, 0);
    cycle(1, 0, 0);
    n_checks++; if (disp !== exp_disp() || lap_active !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("FAIL lap_to_pause: got %h lap=%b run=%b want %h/0/0", disp, lap_active, running, exp_disp()); end
    cycle(0, 1, 0);
  endtask

  task automatic test_mode();
    mode = 0;
    cycle(1, 0, 0);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL mode_start: got %b want 0", running); end
    mode = 1; cycle(1, 0, 0);
    repeat (10) cycle(0, 0, 0);
    mode = 0; cycle(0, 0, 1);
    n_checks++; if (lap_active !== 1'b0) begin n_fail++; $display("FAIL mode_lap: got %b want 0", lap_active); end
    cycle(1, 0, 0);
    repeat (8) cycle(0, 0, 0);
    n_checks++; if (running !== 1'b1 || disp !== exp_disp()) begin
      n_fail++; $display("FAIL mode_bg: got run=%b disp=%h want 1/%h", running, disp, exp_disp()); end
    mode = 1; cycle(1, 0, 0);
    mode = 0; cycle(0, 1, 0);
    n_checks++; if (disp !== exp_disp() || disp === 24'h0) begin
      n_fail++; $display("FAIL mode_clr: got %h want %h", disp, exp_disp()); end
    mode = 1; cycle(1, 1, 0);
    n_checks++; if (running !== 1'b1 || disp !== exp_disp() || disp === 24'h0) begin
      n_fail++; $display("FAIL start_clr_prio: got run=%b disp=%h want 1/%h", running, disp, exp_disp()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      mode = ($urandom_range(0, 9) != 0);
      cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);
      n_checks++; if (disp !== exp_disp()) begin n_fail++; $display("FAIL rand_disp k=%0d: got %h want %h", k, disp, exp_disp()); end
      n_checks++; if (running !== exp_running() || lap_active !== (m_state == M_LAP) || wrap !== m_wrap) begin
        n_fail++; $display("FAIL rand_flags k=%0d: got %b%b%b want %b%b%b", k, running, lap_active, wrap,
                           exp_running(), m_state == M_LAP, m_wrap); end
    end
    mode = 1;
  endtask

  task automatic test_reset_mid();
    int guard;
    rst = 1; #2; rst = 0; model_reset();
    @(negedge clk);
    cycle(1, 0, 0);
    guard = 0;
    while (m_cnt != 327 && guard < 5000) begin cycle(0, 0, 0); guard++; end
    n_checks++; if (disp !== 24'h000327) begin n_fail++; $display("FAIL pre_reset: got %h want 000327 (guard %0d)", disp, guard); end
    #1 rst = 1;
    #1;
    n_checks++; if (disp !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got disp=%h run=%b lap=%b wrap=%b want all 0", disp, running, lap_active, wrap); end
    #1 rst = 0; model_reset();
    @(negedge clk);
    cycle(0, 0, 0);
    n_checks++; if (disp !== 24'h0 || running !== 1'b0) begin n_fail++; $display("FAIL post_reset: got %h run=%b want 0", disp, running); end
    cycle(1, 0, 0);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL post_reset_start: got %b want 1", running); end
  endtask

  task automatic test_wrap();
    int wraps;
    wraps = 0;
    @(negedge clk); rst1 = 0; bs1 = 1;
    @(posedge clk); @(negedge clk); bs1 = 0;
    for (int k = 1; k <= FULL + 1; k++) begin
      @(posedge clk); @(negedge clk);
      if (w1 === 1'b1) wraps++;
      if (k == FULL - 1) begin
        n_checks++; if (disp1 !== 24'h595999) begin n_fail++; $display("FAIL wrap_max: got %h want 595999", disp1); end
      end
      if (k == FULL) begin
        n_checks++; if (disp1 !== 24'h0 || w1 !== 1'b1 || run1 !== 1'b1) begin
          n_fail++; $display("FAIL wrap_roll: got %h wrap=%b run=%b want 000000/1/1", disp1, w1, run1); end
      end
      if (k == FULL + 1) begin
        n_checks++; if (disp1 !== 24'h000001 || w1 !== 1'b0 || lap1 !== 1'b0) begin
          n_fail++; $display("FAIL wrap_after: got %h wrap=%b lap=%b want 000001/0/0", disp1, w1, lap1); end
      end
    end
    n_checks++; if (wraps != 1) begin n_fail++; $display("FAIL wrap_count: got %0d want 1", wraps); end
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_pause_clear();
    test_lap();
    test_mode();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
